egg_timer_countdown: RTL and testbench

- Countdown core of the egg timer; sits directly downstream of the slow-clock divider.
- Consumes the divider's divided square wave, counts whole seconds from its rising edges, and decrements a user-set MM:SS value in BCD.
- Drives the divider's enable input and raises an alarm at 0:00.
- Buttons arrive as debounced single-cycle pulses in the CLK domain.

---
 rtl/egg_timer_countdown.sv | 133 +++++++++++++
 tb/tb_egg_timer_countdown.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/egg_timer_countdown.sv
// egg_timer_countdown: BCD MM:SS countdown clocked by the divider's tick edges,
// with pause/resume and a self-clearing alarm at 0:00.
module egg_timer_countdown #(
  parameter int TICKS_PER_SEC = 4,
  parameter int MAX_MIN = 59,
  parameter int ALARM_SECS = 10
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       TICK_IN,
  input  logic       btn_start,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       btn_clear,
  output logic       div_enable,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       alarm
);
  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int AW = $clog2(ALARM_SECS + 1);
  localparam logic [3:0] MT = 4'(MAX_MIN / 10);
  localparam logic [3:0] MO = 4'(MAX_MIN % 10);
  typedef enum logic [1:0] {SET, RUN, PAUSE, ALARM} state_t;
  state_t state, n_state;
  logic s1, s2, s3, tick_edge;
  logic [TW-1:0] tick_cnt, n_tick_cnt;
  logic [AW-1:0] alarm_cnt, n_alarm_cnt;
  logic [3:0] n_mt, n_mo, n_so;
  logic [2:0] n_st;
  logic [7:0] inc_min;
  logic [6:0] inc_sec;
  logic [14:0] dec_time;
  logic is_zero, is_one, tick_wrap, any_btn;
  assign tick_edge = s2 & ~s3;
  assign any_btn = btn_start | btn_min | btn_sec | btn_clear;
  assign tick_wrap = tick_cnt == TW'(TICKS_PER_SEC - 1);
  assign is_zero = {min_tens, min_ones, sec_tens, sec_ones} == 15'd0;
  assign is_one = {min_tens, min_ones, sec_tens, sec_ones} == 15'd1;
  assign inc_min = (min_tens == MT && min_ones == MO) ? 8'd0 :
                   (min_ones == 4'd9) ? {min_tens + 4'd1, 4'd0} : {min_tens, min_ones + 4'd1};
  assign inc_sec = (sec_tens == 3'd5 && sec_ones == 4'd9) ? 7'd0 :
                   (sec_ones == 4'd9) ? {sec_tens + 3'd1, 4'd0} : {sec_tens, sec_ones + 4'd1};
  // Borrow chain: seconds ones -> seconds tens -> minutes ones -> minutes tens
  assign dec_time = (sec_ones != 4'd0) ? {min_tens, min_ones, sec_tens, sec_ones - 4'd1} :
                    (sec_tens != 3'd0) ? {min_tens, min_ones, sec_tens - 3'd1, 4'd9} :
                    (min_ones != 4'd0) ? {min_tens, min_ones - 4'd1, 3'd5, 4'd9} :
                                         {min_tens - 4'd1, 4'd9, 3'd5, 4'd9};
  always_comb begin
    n_state = state;
    n_tick_cnt = tick_cnt;
    n_alarm_cnt = alarm_cnt;
    {n_mt, n_mo, n_st, n_so} = {min_tens, min_ones, sec_tens, sec_ones};
    case (state)
      SET: begin
        if (btn_clear) {n_mt, n_mo, n_st, n_so} = 15'd0;
        else if (btn_start) begin
          if (!is_zero) begin
            n_state = RUN;
            n_tick_cnt = '0;
          end
        end
        else if (btn_min) {n_mt, n_mo} = inc_min;
        else if (btn_sec) {n_st, n_so} = inc_sec;
      end
      RUN: begin
        if (btn_clear) begin
          n_state = SET;
          n_tick_cnt = '0;
          {n_mt, n_mo, n_st, n_so} = 15'd0;
        end else begin
          if (tick_edge) begin
            if (tick_wrap) begin
              n_tick_cnt = '0;
              {n_mt, n_mo, n_st, n_so} = dec_time;
              if (is_one) begin
                n_state = ALARM;
                n_alarm_cnt = '0;
              end
            end else n_tick_cnt = tick_cnt + TW'(1);
          end
          if (btn_start && n_state == RUN) n_state = PAUSE;
        end
      end
      PAUSE: begin
        if (btn_clear) begin
          n_state = SET;
          n_tick_cnt = '0;
          {n_mt, n_mo, n_st, n_so} = 15'd0;
        end else if (btn_start) n_state = RUN;
      end
      default: begin
        if (any_btn) begin
          n_state = SET;
          n_tick_cnt = '0;
          n_alarm_cnt = '0;
        end else if (tick_edge) begin
          if (tick_wrap) begin
            n_tick_cnt = '0;
            if (alarm_cnt == AW'(ALARM_SECS - 1)) begin
              n_state = SET;
              n_alarm_cnt = '0;
            end else n_alarm_cnt = alarm_cnt + AW'(1);
          end else n_tick_cnt = tick_cnt + TW'(1);
        end
      end
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      {s1, s2, s3} <= 3'b000;
      state <= SET;
      tick_cnt <= '0;
      alarm_cnt <= '0;
      {min_tens, min_ones, sec_tens, sec_ones} <= 15'd0;
      running <= 1'b0;
      alarm <= 1'b0;
      div_enable <= 1'b0;
    end else begin
      {s1, s2, s3} <= {TICK_IN, s1, s2};
      state <= n_state;
      tick_cnt <= n_tick_cnt;
      alarm_cnt <= n_alarm_cnt;
      {min_tens, min_ones, sec_tens, sec_ones} <= {n_mt, n_mo, n_st, n_so};
      running <= n_state == RUN;
      alarm <= n_state == ALARM;
      div_enable <= n_state == RUN || n_state == ALARM;
    end
  end
endmodule

// File: tb/tb_egg_timer_countdown.sv
// tb_egg_timer_countdown: directed and random stimulus against a seconds-based model of the egg timer.
module tb_egg_timer_countdown;
  localparam int TPS = 4;
  localparam int MAX_MIN = 59;
  localparam int ALARM_SECS = 10;
  localparam int M_SET = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;
  logic CLK = 1'b0, RST_N = 1'b0, TICK_IN = 1'b0;
  logic btn_start = 1'b0, btn_min = 1'b0, btn_sec = 1'b0, btn_clear = 1'b0;
  logic div_enable, running, alarm;
  logic [3:0] min_tens, min_ones, sec_ones;
  logic [2:0] sec_tens;
  int total = 0, bad = 0;
  bit chk = 1'b0;
  typedef struct {
    int mode;
    int secs;
    int tc;
    int ae;
    bit h0, h1, h2;
  } mdl_t;
  localparam mdl_t MRST = '{default: 0};
  mdl_t m = MRST;

  egg_timer_countdown #(.TICKS_PER_SEC(TPS), .MAX_MIN(MAX_MIN), .ALARM_SECS(ALARM_SECS)) dut (
    .CLK(CLK), .RST_N(RST_N), .TICK_IN(TICK_IN),
    .btn_start(btn_start), .btn_min(btn_min), .btn_sec(btn_sec), .btn_clear(btn_clear),
    .div_enable(div_enable), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .running(running), .alarm(alarm)
  );

  always #5 CLK = ~CLK;

  // Time is kept as plain seconds; tick edges come from a 3-deep history of sampled TICK_IN.
  function automatic mdl_t step(mdl_t c, bit t, bit st, bit mn, bit sc, bit cl);
    mdl_t n = c;
    bit ev = c.h1 && !c.h2;
    int mm = c.secs / 60;
    int ss = c.secs % 60;
    n.h2 = c.h1;
    n.h1 = c.h0;
    n.h0 = t;
    case (c.mode)
      M_SET: begin
        if (cl) n.secs = 0;
        else if (st) begin
          if (c.secs != 0) begin
            n.mode = M_RUN;
            n.tc = 0;
          end
        end
        else if (mn) n.secs = ((mm == MAX_MIN) ? 0 : mm + 1) * 60 + ss;
        else if (sc) n.secs = mm * 60 + ((ss == 59) ? 0 : ss + 1);
      end
      M_RUN: begin
        if (cl) begin
          n.mode = M_SET;
          n.secs = 0;
          n.tc = 0;
        end else begin
          if (ev) begin
            if (c.tc == TPS - 1) begin
              n.tc = 0;
              n.secs = c.secs - 1;
              if (n.secs == 0) begin
                n.mode = M_ALARM;
                n.ae = 0;
              end
            end else n.tc = c.tc + 1;
          end
          if (st && n.mode == M_RUN) n.mode = M_PAUSE;
        end
      end
      M_PAUSE: begin
        if (cl) begin
          n.mode = M_SET;
          n.secs = 0;
          n.tc = 0;
        end else if (st) n.mode = M_RUN;
      end
      default: begin
        if (cl || st || mn || sc) begin
          n.mode = M_SET;
          n.ae = 0;
          n.tc = 0;
        end else if (ev) begin
          n.ae = c.ae + 1;
          if (n.ae == ALARM_SECS * TPS) begin
            n.mode = M_SET;
            n.ae = 0;
            n.tc = 0;
          end
        end
      end
    endcase
    return n;
  endfunction

  function automatic logic [17:0] expv(mdl_t c);
    int mm = c.secs / 60;
    int ss = c.secs % 60;
    return {c.mode == M_RUN || c.mode == M_ALARM, 4'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10),
            c.mode == M_RUN, c.mode == M_ALARM};
  endfunction

  always @(posedge CLK or negedge RST_N)
    m <= !RST_N ? MRST : step(m, TICK_IN, btn_start, btn_min, btn_sec, btn_clear);

  always @(negedge CLK) begin
    if (chk) begin
      total++;
      if ({div_enable, min_tens, min_ones, sec_tens, sec_ones, running, alarm} !== expv(m)) begin
        bad++;
        $display("FAIL outputs @%0t: got %h want %h", $time,
                 {div_enable, min_tens, min_ones, sec_tens, sec_ones, running, alarm}, expv(m));
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic press(input logic [3:0] v);
    {btn_clear, btn_start, btn_min, btn_sec} = v;
    cyc(1);
    {btn_clear, btn_start, btn_min, btn_sec} = 4'b0000;
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      TICK_IN = 1'b1;
      cyc(3);
      TICK_IN = 1'b0;
      cyc(3);
    end
  endtask

  task automatic set_time(input int mm, input int ss);
    press(4'b1000);
    repeat (mm) press(4'b0010);
    repeat (ss) press(4'b0001);
  endtask

  // Raises TICK_IN so its detected edge lands on the same clock as the button pulse.
  task automatic tick_with(input logic [3:0] v);
    TICK_IN = 1'b1;
    cyc(2);
    press(v);
    cyc(2);
    TICK_IN = 1'b0;
    cyc(3);
  endtask

  initial begin
    cyc(3);
    RST_N = 1'b1;
    cyc(2);
    chk = 1'b1;
    set_time(0, 45);
    press(4'b0100);
    edges(2);
    #1 RST_N = 1'b0;
    #1;
    check("async_rst_sec_tens", sec_tens, 0);
    check("async_rst_running", running, 0);
    check("async_rst_div_en", div_enable, 0);
    cyc(1);
    RST_N = 1'b1;
    cyc(1);
    press(4'b0100);
    check("start_at_zero_ignored", running, 0);

    set_time(0, 3);
    press(4'b0100);
    check("basic_running", running, 1);
    check("basic_div_en", div_enable, 1);
    edges(12);
    check("basic_alarm", alarm, 1);
    check("basic_not_running", running, 0);
    edges(40);
    check("alarm_timeout", alarm, 0);
    check("alarm_timeout_div_en", div_enable, 0);

    set_time(1, 0);
    press(4'b0100);
    edges(4);
    check("borrow1_digits", {min_ones, 1'b0, sec_tens, sec_ones}, 12'h059);
    set_time(10, 0);
    press(4'b0100);
    edges(4);
    check("borrow10_digits", {min_tens, min_ones, 1'b0, sec_tens, sec_ones}, 16'h0959);

    set_time(60, 0);
    check("min_wrap", {min_tens, min_ones}, 0);
    set_time(2, 60);
    check("sec_wrap_keeps_min", {min_tens, min_ones, 1'b0, sec_tens, sec_ones}, 16'h0200);
    press(4'b0011);
    check("min_over_sec", {min_tens, min_ones, 1'b0, sec_tens, sec_ones}, 16'h0300);

    set_time(0, 10);
    press(4'b0100);
    edges(6);
    check("pause_pre", {1'b0, sec_tens, sec_ones}, 8'h09);
    press(4'b0100);
    check("pause_div_en", div_enable, 0);
    edges(8);
    check("pause_hold", {1'b0, sec_tens, sec_ones}, 8'h09);
    press(4'b0100);
    edges(2);
    check("resume_dec", {1'b0, sec_tens, sec_ones}, 8'h08);

    set_time(0, 5);
    press(4'b0100);
    tick_with(4'b1000);
    check("tick_clear_sec", sec_ones, 0);
    check("tick_clear_running", running, 0);
    set_time(0, 5);
    press(4'b0100);
    edges(3);
    tick_with(4'b0100);
    check("tick_start_sec", sec_ones, 4);
    check("tick_start_paused", running, 0);
    check("tick_start_div_en", div_enable, 0);
    set_time(0, 1);
    press(4'b0100);
    edges(4);
    check("alarm_hit", alarm, 1);
    press(4'b0001);
    check("alarm_btn_exit", alarm, 0);
    check("alarm_btn_no_sec", sec_ones, 0);

    set_time(0, 8);
    for (int i = 0; i < 6000; i++) begin
      int r;
      if ($urandom_range(0, 2) == 0) TICK_IN = ~TICK_IN;
      r = $urandom_range(0, 599);
      if (r < 6) btn_start = 1'b1;
      else if (r < 21) btn_sec = 1'b1;
      else if (r < 23) btn_min = 1'b1;
      else if (r < 24) btn_clear = 1'b1;
      else if (r < 27) {btn_clear, btn_start, btn_min, btn_sec} = 4'($urandom_range(0, 15));
      cyc(1);
      {btn_clear, btn_start, btn_min, btn_sec} = 4'b0000;
    end
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
